// File: rtl/guess_scorer.sv
// guess_scorer: multi-cycle Wordle row scorer with duplicate-letter handling.
// Ports: clk, clr (async, active-high); start, guess[25], target[25] in;
//        busy, done, colours[10], result_row[35], win out.
module guess_scorer #(
  parameter int NUM_LETTERS = 5,
  parameter int LETTER_W    = 5,
  parameter int SLOT_W      = 7
) (
  input  logic                            clk,
  input  logic                            clr,
  input  logic                            start,
  input  logic [NUM_LETTERS*LETTER_W-1:0] guess,
  input  logic [NUM_LETTERS*LETTER_W-1:0] target,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_LETTERS*2-1:0]        colours,
  output logic [NUM_LETTERS*SLOT_W-1:0]   result_row,
  output logic                            win
);

  localparam logic [LETTER_W-1:0] MAX_L = LETTER_W'(25);

  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, DONE} state_t;

  state_t state, nxt;

  logic [NUM_LETTERS*LETTER_W-1:0] g_q, t_q;
  logic [NUM_LETTERS-1:0]          green_q, cons_q;
  logic [1:0]                      col_q [NUM_LETTERS];
  logic [2:0]                      idx_q;
  logic                            done_q, win_q;
  logic [NUM_LETTERS*2-1:0]        colours_q;
  logic [NUM_LETTERS*SLOT_W-1:0]   row_q;

  logic [LETTER_W-1:0]             g_l [NUM_LETTERS];
  logic [LETTER_W-1:0]             t_l [NUM_LETTERS];
  logic [NUM_LETTERS-1:0]          green_v, y_oh;
  logic [LETTER_W-1:0]             cur;
  logic                            y_hit;
  logic [NUM_LETTERS*2-1:0]        col_pk;
  logic [NUM_LETTERS*SLOT_W-1:0]   row_pk;
  logic                            accept;

  // done_q doubles as the DONE-visible cycle, so IDLE must not accept then
  assign accept = (state == IDLE) && start && !done_q;

  always_comb begin
    for (int i = 0; i < NUM_LETTERS; i++) begin
      g_l[i]     = g_q[i*LETTER_W +: LETTER_W];
      t_l[i]     = t_q[i*LETTER_W +: LETTER_W];
      green_v[i] = (g_l[i] == t_l[i]) && (g_l[i] <= MAX_L);
      col_pk[i*2 +: 2]         = col_q[i];
      row_pk[i*SLOT_W +: SLOT_W] = {col_q[i], g_l[i]};
    end
  end

  // lowest unconsumed target slot holding the current guess letter;
  // a green position never consumes a second slot
  always_comb begin
    y_oh  = '0;
    y_hit = 1'b0;
    cur   = g_l[idx_q];
    for (int j = 0; j < NUM_LETTERS; j++) begin
      if (!y_hit && !green_q[idx_q] && !cons_q[j] &&
          (cur <= MAX_L) && (t_l[j] == cur)) begin
        y_hit   = 1'b1;
        y_oh[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = GREEN;
      GREEN:   nxt = YELLOW;
      YELLOW:  if (idx_q == 3'd4) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      g_q       <= '0;
      t_q       <= '0;
      green_q   <= '0;
      cons_q    <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      win_q     <= 1'b0;
      colours_q <= '0;
      row_q     <= '0;
      for (int i = 0; i < NUM_LETTERS; i++) col_q[i] <= 2'b00;
    end else begin
      done_q <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (accept) begin
            g_q     <= guess;
            t_q     <= target;
            green_q <= '0;
            cons_q  <= '0;
            for (int i = 0; i < NUM_LETTERS; i++) col_q[i] <= 2'b00;
          end
        end
        GREEN: begin
          green_q <= green_v;
          cons_q  <= green_v;
          idx_q   <= 3'd0;
        end
        YELLOW: begin
          if (green_q[idx_q])  col_q[idx_q] <= 2'b11;
          else if (y_hit)      col_q[idx_q] <= 2'b10;
          else                 col_q[idx_q] <= 2'b01;
          cons_q <= cons_q | y_oh;
          if (idx_q != 3'd4) idx_q <= idx_q + 3'd1;
        end
        DONE: begin
          colours_q <= col_pk;
          row_q     <= row_pk;
          win_q     <= &green_q;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != IDLE) || done_q;
  assign done       = done_q;
  assign colours    = colours_q;
  assign result_row = row_q;
  assign win        = win_q;

endmodule

// File: tb/tb_guess_scorer.sv
// tb_guess_scorer: randomized + directed bench for guess_scorer.
// Reference model scores words with letter counts, cycle-timed by a countdown.
module tb_guess_scorer;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [24:0] guess = '0;
  logic [24:0] target = '0;
  logic        busy, done, win;
  logic [9:0]  colours;
  logic [34:0] result_row;

  guess_scorer dut (
    .clk(clk), .clr(clr), .start(start),
    .guess(guess), .target(target),
    .busy(busy), .done(done), .colours(colours),
    .result_row(result_row), .win(win)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [24:0] pk(input int a0, a1, a2, a3, a4);
    return {5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  // Wordle scoring from letter counts: greens first, then
  // remaining target letters handed out left to right.
  function automatic logic [9:0] score(input logic [24:0] g,
                                       input logic [24:0] t);
    int avail [32];
    logic [9:0] c;
    logic [4:0] gl, tl;
    c = '0;
    for (int k = 0; k < 32; k++) avail[k] = 0;
    for (int i = 0; i < 5; i++) begin
      gl = g[i*5 +: 5];
      tl = t[i*5 +: 5];
      if (gl == tl && gl < 5'd26) c[i*2 +: 2] = 2'b11;
      else if (tl < 5'd26) avail[tl]++;
    end
    for (int i = 0; i < 5; i++) begin
      gl = g[i*5 +: 5];
      if (c[i*2 +: 2] != 2'b11) begin
        if (gl < 5'd26 && avail[gl] > 0) begin
          c[i*2 +: 2] = 2'b10;
          avail[gl]--;
        end else begin
          c[i*2 +: 2] = 2'b01;
        end
      end
    end
    return c;
  endfunction

  function automatic logic [34:0] mkrow(input logic [9:0] c,
                                        input logic [24:0] g);
    logic [34:0] r;
    for (int i = 0; i < 5; i++) r[i*7 +: 7] = {c[i*2 +: 2], g[i*5 +: 5]};
    return r;
  endfunction

  // model: an accepted start sets a countdown of 8 busy cycles;
  // results publish when the countdown reaches 1 (the done cycle)
  int          m_cnt = 0;
  logic [9:0]  p_col = '0, m_col = '0;
  logic [24:0] p_g = '0;
  logic [34:0] m_row = '0;
  logic        m_win = 1'b0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_cnt <= 0;
      m_col <= '0;
      m_row <= '0;
      m_win <= 1'b0;
    end else begin
      if (m_cnt == 0 && start) begin
        m_cnt <= 8;
        p_col <= score(guess, target);
        p_g   <= guess;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
      end
      if (m_cnt == 2) begin
        m_col <= p_col;
        m_row <= mkrow(p_col, p_g);
        m_win <= (p_col == 10'h3FF);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_cnt > 0));
    chk("done", 64'(done), 64'(m_cnt == 1));
    chk("colours", 64'(colours), 64'(m_col));
    chk("row", 64'(result_row), 64'(m_row));
    chk("win", 64'(win), 64'(m_win));
    if (done) n_done++;
  end

  task automatic run_word(input string nm, input logic [24:0] g,
                          input logic [24:0] t, input logic [9:0] ec,
                          input logic ew);
    int lat;
    @(negedge clk);
    start  = 1'b1;
    guess  = g;
    target = t;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'd8);
    chk({nm, "_col"}, 64'(colours), 64'(ec));
    chk({nm, "_win"}, 64'(win), 64'(ew));
  endtask

  function automatic logic [4:0] rl();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 8)  return 5'($urandom_range(0, 4));
    if (r == 8) return 5'($urandom_range(0, 25));
    return 5'($urandom_range(26, 31));
  endfunction

  initial begin
    int d0;
    logic [24:0] tw;
    #1 clr = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_col", 64'(colours), 64'd0);
    chk("rst_row", 64'(result_row), 64'd0);
    chk("rst_win", 64'(win), 64'd0);
    @(negedge clk);
    #2 clr = 1'b0;

    tw = pk(4, 3, 2, 1, 0);
    run_word("t1", tw, tw, 10'h3FF, 1'b1);
    chk("t1_slot0", 64'(result_row[6:0]), 64'(7'b1100100));
    run_word("t2", pk(0, 1, 2, 3, 4), tw, 10'b1010111010, 1'b0);
    run_word("t3a", pk(0, 0, 9, 9, 0), pk(1, 0, 2, 3, 4),
             10'b0101011101, 1'b0);
    run_word("t3b", pk(9, 0, 0, 9, 9), pk(0, 5, 6, 7, 8),
             10'b0101011001, 1'b0);
    run_word("t4", pk(26, 3, 2, 1, 31), tw, 10'b0111111101, 1'b0);
    chk("t4_slot0_letter", 64'(result_row[4:0]), 64'd26);

    // start held for 10 edges: one accept, then a re-accept in IDLE
    @(negedge clk);
    d0 = n_done;
    start = 1'b1;
    guess = tw;
    target = tw;
    repeat (10) @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("held_start_dones", 64'(n_done - d0), 64'd2);

    // guess changes mid-scoring must not leak into the result
    @(negedge clk);
    start = 1'b1;
    guess = pk(0, 1, 2, 3, 4);
    target = tw;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    guess = tw;
    d0 = 0;
    while (!done && d0 < 20) begin
      @(negedge clk);
      d0++;
    end
    chk("latched_col", 64'(colours), 64'(10'b1010111010));

    // abort during YELLOW idx 2
    run_word("pre_clr", tw, tw, 10'h3FF, 1'b1);
    @(negedge clk);
    start = 1'b1;
    guess = pk(0, 1, 2, 3, 4);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_col", 64'(colours), 64'd0);
    chk("clr_win", 64'(win), 64'd0);
    @(negedge clk);
    #2 clr = 1'b0;
    d0 = n_done;
    repeat (12) @(negedge clk);
    chk("clr_no_done", 64'(n_done - d0), 64'd0);
    run_word("post_clr", pk(0, 0, 9, 9, 0), pk(1, 0, 2, 3, 4),
             10'b0101011101, 1'b0);

    // random traffic, including starts while busy and rare aborts
    repeat (600) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 5; i++) begin
        guess[i*5 +: 5]  = rl();
        target[i*5 +: 5] = rl();
      end
      if ($urandom_range(0, 5) == 0) guess = target;
      if ($urandom_range(0, 79) == 0) begin
        #2 clr = 1'b1;
        @(negedge clk);
        #2 clr = 1'b0;
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
